// File: rtl/pin_checker.sv
// pin_checker: ATM PIN entry FSM with digit buffering, compare pulses and 3-strike lockout
module pin_checker (
  input  logic        clk,
  input  logic        rst,
  input  logic        pinStart,
  input  logic        digitValid,
  input  logic [3:0]  digit,
  input  logic        clearEntry,
  input  logic        sessionEnd,
  input  logic [15:0] storedPin,
  output logic        correctPassword,
  output logic        wrongPassword,
  output logic        locked,
  output logic [2:0]  digitCount,
  output logic [1:0]  attemptCount,
  output logic [1:0]  pinState
);
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] COLLECT = 2'b01;
  localparam logic [1:0] COMPARE = 2'b10;
  localparam logic [1:0] LOCKED  = 2'b11;
  logic [15:0] pinBuf;
  logic        digitOk;
  logic        match;
  assign digitOk = digitValid && (digit <= 4'd9);
  assign match   = (pinBuf == storedPin);
  always_ff @(posedge clk) begin
    if (!rst || sessionEnd) begin
      pinState        <= IDLE;
      pinBuf          <= '0;
      digitCount      <= '0;
      attemptCount    <= '0;
      correctPassword <= 1'b0;
      wrongPassword   <= 1'b0;
      locked          <= 1'b0;
    end else begin
      correctPassword <= 1'b0;
      wrongPassword   <= 1'b0;
      case (pinState)
        IDLE: if (pinStart) begin
          pinState   <= COLLECT;
          pinBuf     <= '0;
          digitCount <= '0;
        end
        COLLECT: if (clearEntry) begin
          pinBuf     <= '0;
          digitCount <= '0;
        end else if (digitOk) begin
          pinBuf     <= {pinBuf[11:0], digit};
          digitCount <= digitCount + 3'd1;
          pinState   <= (digitCount == 3'd3) ? COMPARE : COLLECT;
        end
        COMPARE: begin
          digitCount      <= '0;
          pinBuf          <= '0;
          correctPassword <= match;
          wrongPassword   <= !match;
          attemptCount    <= match ? 2'd0 : attemptCount + 2'd1;
          locked          <= !match && (attemptCount == 2'd2);
          pinState        <= match ? IDLE : (attemptCount == 2'd2) ? LOCKED : COLLECT;
        end
        default: locked <= 1'b1;
      endcase
    end
  end
endmodule

// File: doc/pin_checker.md
PIN_CHECKER -- requirements
Module: pin_checker

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous active-low reset, sampled at the rising edge of clk.
REQ-003 SHALL have port pinStart, input, 1 bit: ATM has entered password entry; begin a PIN session.
REQ-004 SHALL have port digitValid, input, 1 bit: keypad digit is present on digit this cycle.
REQ-005 SHALL have port digit, input, 4 bits: keypad value, legal range 0-9.
REQ-006 SHALL have port clearEntry, input, 1 bit: discard digits typed in the current attempt.
REQ-007 SHALL have port sessionEnd, input, 1 bit: card removed or cancelled; abort and clear everything.
REQ-008 SHALL have port storedPin, input, 16 bits: account PIN as four BCD digits, first digit in [15:12].
REQ-009 SHALL have port correctPassword, output, 1 bit: one-cycle pulse on PIN match; feeds the ATM controller.
REQ-010 SHALL have port wrongPassword, output, 1 bit: one-cycle pulse on PIN mismatch.
REQ-011 SHALL have port locked, output, 1 bit: level, high while the card is retained after 3 failures.
REQ-012 SHALL have port digitCount, output, 3 bits: digits accepted in the current attempt, 0-4.
REQ-013 SHALL have port attemptCount, output, 2 bits: failed attempts in the current session, 0-3.
REQ-014 SHALL have port pinState, output, 2 bits: encodes IDLE=00, COLLECT=01, COMPARE=10, LOCKED=11.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 IDLE: pinStart=1 SHALL move to COLLECT and clear the digit buffer and digitCount; attemptCount SHALL be retained.
REQ-017 COLLECT: digitValid=1 with digit<=9 SHALL shift the digit into the buffer ({buf[11:0],digit}) and increment digitCount.
REQ-018 digitValid=1 with digit>9 SHALL be ignored; buffer and digitCount unchanged.
REQ-019 The edge that accepts the 4th digit SHALL move the FSM to COMPARE.
REQ-020 clearEntry=1 in COLLECT SHALL clear the buffer and set digitCount=0; it overrides a simultaneous digitValid, whose digit is dropped.
REQ-021 COMPARE SHALL last exactly one cycle and compare the buffer with storedPin sampled in that cycle.
REQ-022 On match: correctPassword=1 for exactly one cycle, attemptCount:=0, digitCount:=0, next state IDLE.
REQ-023 On mismatch: wrongPassword=1 for one cycle, attemptCount+1, digitCount:=0, buffer cleared.
REQ-024 After a mismatch, the FSM SHALL go to LOCKED if the new attemptCount is 3, otherwise to COLLECT.
REQ-025 Latency: 4th digit accepted at edge N -> pinState=COMPARE after N -> result pulse high from edge N+1 to edge N+2.
REQ-026 LOCKED: locked=1; digitValid, clearEntry and pinStart SHALL be ignored; attemptCount held at 3, never wraps.
REQ-027 sessionEnd=1 in any state SHALL force IDLE on the next edge, clear buffer, digitCount and attemptCount, and drop locked and pulses; it overrides all inputs except rst.
REQ-028 pinStart while in COLLECT, COMPARE or LOCKED SHALL be ignored.
REQ-029 digitValid and clearEntry in IDLE or COMPARE SHALL be ignored.
REQ-030 correctPassword and wrongPassword SHALL never be high in the same cycle.

Reset
REQ-031 When rst=0 at a clock edge: pinState=IDLE, buffer=0, digitCount=0, attemptCount=0, correctPassword=0, wrongPassword=0, locked=0.
REQ-032 rst=0 SHALL take priority over every input, including mid-entry and LOCKED.
REQ-033 No output SHALL pulse in the first cycle after rst is released.

Verification (storedPin=16'h1234)
REQ-034 Correct PIN: pinStart, then digits 1,2,3,4 on consecutive cycles -> pinState 00->01->10->00; single correctPassword pulse one cycle after COMPARE; attemptCount=0.
REQ-035 Wrong then right: 1,2,3,5 -> wrongPassword pulse, attemptCount=1, pinState=01, digitCount=0; then 1,2,3,4 -> correctPassword pulse, attemptCount=0.
REQ-036 Lockout: three wrong entries -> attemptCount=3, locked=1, pinState=11; further digits 1,2,3,4 produce no pulse; sessionEnd -> pinState=00, locked=0, attemptCount=0.
REQ-037 Clear: digits 1,2, then clearEntry together with digitValid(9) -> digitCount=0, digit 9 dropped; then 1,2,3,4 -> pass.
REQ-038 Illegal/reset: digit 4'hA -> digitCount unchanged; rst=0 after two digits -> all outputs 0 and pinState=00 at the next edge.
